// File: rtl/icache.sv
// Direct-mapped, one-word-per-line, read-only instruction cache.
// It serves fetches from the datapath. On a miss it fills the line from the memory controller.
module icache #(
    parameter int NSETS = 16,
    parameter int IDX_W = $clog2(NSETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, next_state;
    logic [NSETS-1:0]  valid;
    logic [TAG_W-1:0]  tag_q  [NSETS];
    logic [31:0]       data_q [NSETS];
    logic [31:0]       miss_addr;

    logic [IDX_W-1:0]  idx, miss_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit, fill_done, miss_start;
    logic              unused_byte_offset;

    assign idx        = imemaddr[IDX_W+1:2];
    assign req_tag    = imemaddr[31:IDX_W+2];
    assign miss_idx   = miss_addr[IDX_W+1:2];
    assign hit        = imemREN & valid[idx] & (tag_q[idx] == req_tag);
    assign fill_done  = (state == FILL) & ~iwait;
    assign miss_start = (state == IDLE) & imemREN & ~hit;
    assign unused_byte_offset = ^imemaddr[1:0];

    // State register; reset also aborts an outstanding fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Valid bits and the latched miss address; only these need reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid     <= '0;
            miss_addr <= '0;
        end else begin
            if (miss_start) miss_addr <= {imemaddr[31:2], 2'b00};
            if (fill_done)  valid[miss_idx] <= 1'b1;
        end
    end

    // Tag/data arrays: written only when a fill completes, never reset.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[miss_idx]  <= miss_addr[31:IDX_W+2];
            data_q[miss_idx] <= iload;
        end
    end

    // Next-state and output decode; iaddr always comes straight from miss_addr.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = miss_addr;
        case (state)
            IDLE: begin
                ihit = hit;
                if (hit) imemload = data_q[idx];
                if (miss_start) next_state = FILL;
            end
            FILL: begin
                iREN = 1'b1;
                if (!iwait) next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a line-level reference model plus directed and random fetches.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    icache #(.NSETS(16)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    // Backing memory contents: a few fixed words, a hash elsewhere.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1111_1111;
            32'h0000_0004: return 32'h8C22_0000;
            32'h0000_0040: return 32'h2222_2222;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: each line remembers which word address it holds.
    bit          m_v    [16];
    logic [29:0] m_word [16];
    logic [31:0] m_data [16];
    bit          m_busy;
    logic [31:0] m_pend;

    function automatic bit m_hit(input logic [31:0] a);
        return m_v[a[5:2]] && (m_word[a[5:2]] == a[31:2]);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
            m_busy = 1'b0;
            m_pend = '0;
        end else if (m_busy) begin
            if (!iwait) begin
                m_v[m_pend[5:2]]    = 1'b1;
                m_word[m_pend[5:2]] = m_pend[31:2];
                m_data[m_pend[5:2]] = mem_rd(m_pend);
                m_busy = 1'b0;
            end
        end else if (imemREN && !m_hit(imemaddr)) begin
            m_busy = 1'b1;
            m_pend = {imemaddr[31:2], 2'b00};
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge CLK) begin
        if (nRST && cmp_en) begin
            logic        eh;
            logic [31:0] ed;
            eh = !m_busy && imemREN && m_hit(imemaddr);
            ed = eh ? m_data[imemaddr[5:2]] : 32'h0;
            chk("ihit",     {31'b0, ihit}, {31'b0, eh});
            chk("imemload", imemload, ed);
            chk("iREN",     {31'b0, iREN}, {31'b0, m_busy});
            chk("iaddr",    iaddr, m_pend);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        iload = mem_rd(m_pend);
    endtask

    // Fetch one address until ihit, with `waits` busy cycles during any fill.
    task automatic fetch(input logic [31:0] a, input int waits,
                         input logic [31:0] exp_data, input int exp_lat);
        int  wcnt;
        bit  done;
        wcnt = 0;
        done = 1'b0;
        imemREN  = 1'b1;
        imemaddr = a;
        for (int n = 1; n <= 60 && !done; n++) begin
            iwait = (wcnt < waits);
            iload = mem_rd(m_pend);
            @(negedge CLK);
            if (ihit) begin
                chk("fetch_latency", n, exp_lat);
                chk("fetch_data", imemload, exp_data);
                done = 1'b1;
            end else if (m_busy && iwait) begin
                wcnt++;
            end
            tick();
        end
        if (!done) chk("fetch_timeout", 32'd0, 32'd1);
        imemREN = 1'b0;
        iwait   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: reset, idle for 5 cycles
        #12 nRST = 1'b1;
        cmp_en = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("idle_outputs", {31'b0, ihit | iREN} | iaddr | imemload, 32'h0);
            tick();
        end

        // 2: cold miss with 2 wait cycles -> ihit on cycle 5
        fetch(32'h4, 2, 32'h8C22_0000, 5);
        // 3: re-fetch, byte offset ignored
        fetch(32'h4, 0, 32'h8C22_0000, 1);
        fetch(32'h6, 0, 32'h8C22_0000, 1);
        // 4: conflict on index 0
        fetch(32'h0,  0, 32'h1111_1111, 3);
        fetch(32'h40, 0, 32'h2222_2222, 3);
        fetch(32'h0,  0, 32'h1111_1111, 3);

        // 5: address change mid-fill
        imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1;
        tick();
        tick();
        imemaddr = 32'hC;
        @(negedge CLK);
        chk("stale_fill_iaddr", iaddr, 32'h8);
        chk("stale_fill_iREN", {31'b0, iREN}, 32'd1);
        tick();
        iwait = 1'b0;
        tick();
        @(negedge CLK);
        chk("after_stale_ihit", {31'b0, ihit}, 32'd0);
        tick();
        @(negedge CLK);
        chk("new_miss_iaddr", iaddr, 32'hC);
        chk("new_miss_iREN", {31'b0, iREN}, 32'd1);
        tick();
        @(negedge CLK);
        chk("new_miss_hit", {31'b0, ihit}, 32'd1);
        chk("new_miss_data", imemload, mem_rd(32'hC));
        tick();
        imemREN = 1'b0;
        fetch(32'h8, 0, mem_rd(32'h8), 1);

        // 6: reset during fill aborts it
        imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
        tick();
        tick();
        #1 nRST = 1'b0;
        #1;
        chk("abort_iREN", {31'b0, iREN}, 32'd0);
        chk("abort_iaddr", iaddr, 32'h0);
        imemREN = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        fetch(32'h10, 0, mem_rd(32'h10), 3);
        fetch(32'h4,  0, 32'h8C22_0000, 3);

        // Random traffic over 48 words (3 tags per index).
        for (int i = 0; i < 600; i++) begin
            imemREN  = ($urandom_range(0, 3) != 0);
            imemaddr = {$urandom_range(0, 47), 2'b00} | 32'($urandom_range(0, 3));
            iwait    = $urandom_range(0, 1);
            iload    = mem_rd(m_pend);
            @(posedge CLK);
            #1;
        end
        imemREN = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
